// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter family.
// Holds the direction encodings, the bit-cell mux select encoding and
// the load clamp helper used by the top level.
package counter_pkg;

  // Direction encodings as seen on the `up` input and the direction register.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Bit-cell next-state select, formed as {load, en}.
  // Both load encodings pick the parallel input, so load always wins over en.
  typedef enum logic [1:0] {
    SEL_HOLD    = 2'b00,
    SEL_NEXT    = 2'b01,
    SEL_LOAD    = 2'b10,
    SEL_LOAD_EN = 2'b11
  } cell_sel_e;

  // Out-of-range load values land on the top of the count range.
  // This keeps the counter inside 0..modulus-1 even after a bad load.
  function automatic int unsigned clamp_load(input int unsigned value,
                                             input int unsigned modulus);
    if (value < modulus) begin
      return value;
    end
    return modulus - 1;
  endfunction

endpackage

// File: rtl/cnt_bit_cell.sv
// One bit of the counter register: a flop fed by a 4-input mux.
// The mux chooses hold / next / in / in from the {load, en} select, so
// the top level only needs to supply the per-bit next value and load value.
module cnt_bit_cell
  import counter_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  cell_sel_e sel_i,
  input  logic      next_i,
  input  logic      in_i,
  output logic      q_o
);

  logic bit_q;
  logic bit_d;

  // Select the value this bit takes on the next rising edge.
  always_comb begin
    bit_d = bit_q;
    unique case (sel_i)
      SEL_HOLD:    bit_d = bit_q;
      SEL_NEXT:    bit_d = next_i;
      SEL_LOAD:    bit_d = in_i;
      SEL_LOAD_EN: bit_d = in_i;
      default:     bit_d = bit_q;
    endcase
  end

  // Storage flop; reset drops straight to this bit of the reset value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_q <= RST_BIT;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/mod_updown_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with synchronous parallel load,
// count enable, a combinational carry/borrow look-ahead (co) and a
// terminal-count flag (tc) derived from registered state.
// Stages cascade by wiring co of the lower stage into en of the upper one;
// because co is combinational both stages move on the same edge.
// Build option: define COUNTER_SAT_EN to make the counter stop at its
// limits instead of wrapping; the port list is the same either way.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count,
  output logic             co,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] incr_val;
  logic [WIDTH-1:0] decr_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             at_max;
  logic             at_zero;
  logic             dir_q;
  logic             dir_d;
  cell_sel_e        sel;

  // The modulo compare is exact, so a non power-of-two range wraps at
  // MODULUS-1 rather than at the natural all-ones value.
  assign at_max  = (cnt_q == MAX_VAL);
  assign at_zero = (cnt_q == '0);

  // Out-of-range parallel values are clamped before they reach the cells.
  assign load_val = WIDTH'(clamp_load(32'(in), 32'(MODULUS)));

  // Increment and decrement candidates, wrapping or saturating at the ends.
  always_comb begin
    incr_val = cnt_q + WIDTH'(1);
    decr_val = cnt_q - WIDTH'(1);
`ifdef COUNTER_SAT_EN
    if (at_max) begin
      incr_val = cnt_q;
    end
    if (at_zero) begin
      decr_val = cnt_q;
    end
`else
    if (at_max) begin
      incr_val = '0;
    end
    if (at_zero) begin
      decr_val = MAX_VAL;
    end
`endif
  end

  // Direction picks which candidate the cells see as their next value.
  always_comb begin
    step_val = decr_val;
    if (up == DIR_UP) begin
      step_val = incr_val;
    end
  end

  // load outranks en inside each cell because both load codes select in.
  assign sel = cell_sel_e'({load, en});

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    cnt_bit_cell #(
      .RST_BIT(RST_VEC[i])
    ) u_cell (
      .clk_i (clk),
      .rst_ni(rst),
      .sel_i (sel),
      .next_i(step_val[i]),
      .in_i  (load_val[i]),
      .q_o   (cnt_q[i])
    );
  end

  // Direction is captured on any edge that moves or loads the counter.
  always_comb begin
    dir_d = dir_q;
    if (en || load) begin
      dir_d = up;
    end
  end

  // Direction register; reset assumes counting up so tc reflects RST_VAL
  // against the top of the range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end

  // co looks ahead one edge and is suppressed while loading.
  assign co = en & ~load & ((up == DIR_UP) ? at_max : at_zero);

  // tc depends only on flops, so it is glitch-free for downstream logic.
  assign tc = (dir_q == DIR_UP) ? at_max : at_zero;

  assign count = cnt_q;

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor of the team's 3-bit loadable counter. It is a WIDTH-bit modulo-MODULUS up/down counter with synchronous parallel load, count enable and a look-ahead carry/borrow output. Instances cascade through `co` into the next stage's `en` to form wider counters. It is used in the datapath controllers for loop indices and timing intervals.

Parameters:
- WIDTH, 3, counter width in bits (≥1).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.
- RST_VAL, 0, value loaded on reset. Must be < MODULUS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- en  input  1  count enable; also the cascade input from a lower stage's `co`.
- load  input  1  synchronous parallel load.
- up  input  1  direction: 1 = increment, 0 = decrement.
- in  input  WIDTH  parallel load value.
- count  output  WIDTH  current counter value.
- co  output  1  combinational carry/borrow look-ahead.
- tc  output  1  registered terminal-count flag.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - count = RST_VAL.
  - tc = (RST_VAL == MODULUS-1).
  - co is combinational and follows its own equation during reset.
- Per-edge priority, highest first: load, then en, then hold.
- load=1:
  - count <= in if in < MODULUS, otherwise count <= MODULUS-1 (clamp).
  - en and up are ignored in that cycle.
- load=0, en=1, up=1:
  - count <= count+1.
  - count == MODULUS-1 wraps to 0.
- load=0, en=1, up=0:
  - count <= count-1.
  - count == 0 wraps to MODULUS-1.
- load=0, en=0: count holds.
- co = en & ~load & (up ? count==MODULUS-1 : count==0).
  - It is purely combinational, with zero-cycle latency, so a stage and the stage above it advance on the same edge.
  - co asserts in the cycle before the wrap edge and never during load.
- tc = 1 whenever the registered count equals the terminal value for the current `up`: MODULUS-1 when up=1, 0 when up=0.
  - tc is recomputed from the registered count and the registered direction. The direction register updates whenever en|load.
- Counter arithmetic is WIDTH bits wide and the modulo compare is exact. When MODULUS == 2**WIDTH, natural overflow gives the same result.
- If `up` changes mid-count, the new direction applies on the next enabled edge. No state is lost.
- If reset asserts mid-operation, count goes to RST_VAL immediately and any pending load/count is discarded.
- Reset deassertion must be synchronised externally. The first edge after release obeys the normal priority.

Optional Feature:
Macro: COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping.
  - Up at MODULUS-1 holds at MODULUS-1.
  - Down at 0 holds at 0.
  - co keeps the same equation but means "at limit". It does not cause a wrap.
  - load behaviour is unchanged.
- Undefined: wrap-around as described in Behaviour.
- Port list is identical in both builds.

Decomposition:
- Shared package `counter_pkg`:
  - localparam direction encodings DIR_DOWN=1'b0 and DIR_UP=1'b1.
  - A function `clamp_load(value, modulus)`.
- One natural sub-module: `cnt_bit_cell`, a per-bit flop with a 4-input next-state mux. The mux selects {hold, next, in, in} from (load, en), matching the team's mux-flop cell style.
- Top level generates WIDTH cell instances plus the increment/decrement and compare logic.

Test Plan (WIDTH=3, MODULUS=6 unless noted):
1. Reset: rst=0 mid-cycle → count=0 and tc=0 at once, without a clock edge. After release with en=0, count holds 0.
2. Up wrap: en=1, up=1 from 0 for 7 edges.
   - count goes 1,2,3,4,5,0,1.
   - co=1 only while count=5.
   - tc=1 only while count=5.
3. Down wrap: load in=2, then en=1, up=0.
   - count goes 2,1,0,5,4.
   - co=1 while count=0.
4. Load priority and clamp:
   - load=1, en=1, in=3 → count=3 next edge, co=0 that cycle.
   - load in=7 → count=5.
5. Cascade: two instances, WIDTH=4, MODULUS=10, low stage `co` driving high stage `en`.
   - 23 enabled edges from 0 → high=2, low=3.
   - High stage steps only on low-stage 9→0 edges.
6. COUNTER_SAT_EN defined:
   - Up from 4 for 3 edges → 5,5,5.
   - Down from 1 for 2 edges → 0,0.
   - co=1 while held at the limit.
